// File: rtl/store_queue.sv
// Store queue: in-order alloc/commit/drain, out-of-order addr/data fill, youngest-match load forwarding.
// State updates are visible the cycle after the edge; the head drains only on o_ret_valid && i_ret_ready.
module store_queue #(
  parameter int WIDTH_TAG  = 5,
  parameter int WIDTH_ADDR = 32,
  parameter int WIDTH_DATA = 32,
  parameter int WIDTH      = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_alloc,
  input  logic [WIDTH_TAG-1:0]  i_alloc_tag,
  output logic [WIDTH-1:0]      o_alloc_idx,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [WIDTH:0]        o_count,
  input  logic                  i_addr_we,
  input  logic [WIDTH-1:0]      i_addr_idx,
  input  logic [WIDTH_ADDR-1:0] i_addr,
  input  logic                  i_data_we,
  input  logic [WIDTH-1:0]      i_data_idx,
  input  logic [WIDTH_DATA-1:0] i_data,
  input  logic                  i_commit,
  input  logic                  i_flush,
  output logic                  o_ret_valid,
  output logic [WIDTH_ADDR-1:0] o_ret_addr,
  output logic [WIDTH_DATA-1:0] o_ret_data,
  output logic [WIDTH_TAG-1:0]  o_ret_tag,
  input  logic                  i_ret_ready,
  input  logic [WIDTH_ADDR-1:0] i_ld_addr,
  output logic                  o_fwd_hit,
  output logic [WIDTH_DATA-1:0] o_fwd_data,
  output logic                  o_fwd_stall
);
  localparam int SIZE = 2 ** WIDTH;

  logic [WIDTH:0]      head, cmt, tail;
  logic [WIDTH:0]      cmt_nxt, tail_nxt, spec_cnt;
  logic [WIDTH-1:0]    head_idx, cmt_idx, tail_idx;
  logic [SIZE-1:0]     valid, addr_v, data_v, committed, flushed;
  logic [WIDTH_TAG-1:0]  tag_q  [SIZE];
  logic [WIDTH_ADDR-1:0] addr_q [SIZE];
  logic [WIDTH_DATA-1:0] data_q [SIZE];
  logic                alloc_fire, cmt_fire, ret_fire, addr_wr, data_wr;
  logic [WIDTH-1:0]    off;
  logic [WIDTH-1:0]    scan_idx, fwd_idx;
  logic                fwd_match, unk_younger;

  assign head_idx = head[WIDTH-1:0];
  assign cmt_idx  = cmt[WIDTH-1:0];
  assign tail_idx = tail[WIDTH-1:0];

  assign o_count     = tail - head;
  assign o_empty     = (head == tail);
  assign o_full      = (head_idx == tail_idx) && (head[WIDTH] != tail[WIDTH]);
  assign o_alloc_idx = tail_idx;

  // Flush wins over alloc; a full queue refuses alloc even if the head drains this cycle.
  assign alloc_fire = i_alloc && !o_full && !i_flush;
  assign cmt_fire   = i_commit && (cmt != tail);
  assign cmt_nxt    = cmt + {{WIDTH{1'b0}}, cmt_fire};
  assign spec_cnt   = tail - cmt_nxt;
  assign tail_nxt   = i_flush ? cmt_nxt : tail + {{WIDTH{1'b0}}, alloc_fire};

  assign o_ret_valid = !o_empty && committed[head_idx] && addr_v[head_idx] && data_v[head_idx];
  assign o_ret_addr  = addr_q[head_idx];
  assign o_ret_data  = data_q[head_idx];
  assign o_ret_tag   = tag_q[head_idx];
  assign ret_fire    = o_ret_valid && i_ret_ready;

  // Entries from the post-commit cmt up to tail-1 are speculative and die on flush.
  always_comb begin
    off     = '0;
    flushed = '0;
    for (int i = 0; i < SIZE; i++) begin
      off        = WIDTH'(i) - cmt_nxt[WIDTH-1:0];
      flushed[i] = i_flush && ({1'b0, off} < spec_cnt);
    end
  end

  assign addr_wr = i_addr_we && valid[i_addr_idx] && !flushed[i_addr_idx]
                   && !(alloc_fire && (i_addr_idx == tail_idx));
  assign data_wr = i_data_we && valid[i_data_idx] && !flushed[i_data_idx]
                   && !(alloc_fire && (i_data_idx == tail_idx));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head      <= '0;
      cmt       <= '0;
      tail      <= '0;
      valid     <= '0;
      addr_v    <= '0;
      data_v    <= '0;
      committed <= '0;
    end else begin
      head <= head + {{WIDTH{1'b0}}, ret_fire};
      cmt  <= cmt_nxt;
      tail <= tail_nxt;
      for (int i = 0; i < SIZE; i++) begin
        if (addr_wr && (i_addr_idx == WIDTH'(i))) addr_v[i] <= 1'b1;
        if (data_wr && (i_data_idx == WIDTH'(i))) data_v[i] <= 1'b1;
        if (cmt_fire && (cmt_idx == WIDTH'(i)))   committed[i] <= 1'b1;
        if ((ret_fire && (head_idx == WIDTH'(i))) || flushed[i]) begin
          valid[i]     <= 1'b0;
          addr_v[i]    <= 1'b0;
          data_v[i]    <= 1'b0;
          committed[i] <= 1'b0;
        end
        if (alloc_fire && (tail_idx == WIDTH'(i))) begin
          valid[i]     <= 1'b1;
          addr_v[i]    <= 1'b0;
          data_v[i]    <= 1'b0;
          committed[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (alloc_fire) tag_q[tail_idx]    <= i_alloc_tag;
    if (addr_wr)    addr_q[i_addr_idx] <= i_addr;
    if (data_wr)    data_q[i_data_idx] <= i_data;
  end

  // Walk oldest to youngest; a later match supersedes, and resets the unknown-address tracking.
  always_comb begin
    scan_idx    = '0;
    fwd_idx     = '0;
    fwd_match   = 1'b0;
    unk_younger = 1'b0;
    for (int k = 0; k < SIZE; k++) begin
      scan_idx = head_idx + WIDTH'(k);
      if (valid[scan_idx]) begin
        if (addr_v[scan_idx] && (addr_q[scan_idx] == i_ld_addr)) begin
          fwd_match   = 1'b1;
          fwd_idx     = scan_idx;
          unk_younger = 1'b0;
        end else if (!addr_v[scan_idx]) begin
          unk_younger = 1'b1;
        end
      end
    end
  end

  assign o_fwd_stall = unk_younger || (fwd_match && !data_v[fwd_idx]);
  assign o_fwd_hit   = fwd_match && data_v[fwd_idx] && !o_fwd_stall;
  assign o_fwd_data  = data_q[fwd_idx];

endmodule
